display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexes the six 7-segment digit patterns (hours/minutes/seconds, MSB/LSB) onto one shared segment bus with one-hot digit selects. Sits between the BCD-to-7-segment stage and the board pins. Inserts a blanking gap between digits to prevent ghosting and applies 8-level PWM brightness. New digit data is captured only at frame boundaries so the display never tears.

Parameters:
DIGIT_CYCLES, 1000, clocks per digit slot; must be greater than BLANK_CYCLES.
BLANK_CYCLES, 8, clocks at the start of each slot with all outputs off; must be at least 1.

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous reset, active-high
i_en  in  1  scan enable
i_hours_msb, i_hours_lsb, i_minutes_msb, i_minutes_lsb, i_seconds_msb, i_seconds_lsb  in  7 each  segment patterns, active-high
i_brightness  in  3  0 = dimmest, 7 = full
o_segments  out  7  shared segment bus
o_digit_sel  out  6  one-hot select; bit5 = hours_msb, down to bit0 = seconds_lsb
o_frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset: asynchronous and active-high. All outputs, shadow registers and counters go to 0; the FSM goes to IDLE.
- All outputs are registered.
- FSM states: IDLE, BLANK, ON, OFF.
- Counters: slot_cnt runs 0..DIGIT_CYCLES-1; dig runs 0..5, with 0 = hours_msb. Scan order is bit5 down to bit0.
- Derived lengths:
  - A = DIGIT_CYCLES - BLANK_CYCLES.
  - on_len = ((brightness_shadow + 1) * A) >> 3, evaluated at full width with no truncation before the shift.
  - on_len is clamped to at least 1.
- IDLE -> BLANK when i_en = 1:
  - slot_cnt = 0, dig = 0.
  - On that same edge, all six patterns and i_brightness load into shadow registers.
- BLANK:
  - o_digit_sel = 0, o_segments = 0.
  - Lasts BLANK_CYCLES cycles, then -> ON.
- ON:
  - o_digit_sel has bit (5 - dig) set; o_segments = shadow[dig].
  - Lasts on_len cycles, then -> OFF.
  - If on_len = A, OFF is skipped and the slot ends directly.
- OFF:
  - Outputs are 0 for the rest of the slot.
- End of slot:
  - If dig < 5: dig increments and the FSM -> BLANK.
  - If dig = 5: dig wraps to 0, the shadow registers reload on that edge, and the FSM -> BLANK.
- Frame timing:
  - o_frame_start is high during the first BLANK cycle of dig 0, in every frame including the first after enable.
  - Frame period = 6 * DIGIT_CYCLES cycles.
- Input changes mid-frame have no effect until the next frame_start.
- i_en sampled 0 in any non-IDLE state: next cycle -> IDLE, outputs 0, counters 0. Re-enabling always starts a fresh frame at hours_msb.
- Asynchronous reset asserted mid-slot forces outputs to 0 immediately, without waiting for a clock edge.

Optional Feature:
DISPLAY_BLINK_EN
- Defined:
  - Adds input i_blink_mask[2:0]: bit2 = hours pair, bit1 = minutes pair, bit0 = seconds pair.
  - Adds parameter BLINK_FRAMES (default 30).
  - A frame counter toggles blink_phase every BLINK_FRAMES frames; blink_phase = 0 after reset and after IDLE.
  - When blink_phase = 1, ON slots of masked pairs behave as OFF: select and segments are 0.
  - The mask is captured into the shadow registers at frame start.
- Undefined: no port, no counter, no parameter effect.

Decomposition:
- Package display_pkg:
  - NUM_DIGITS = 6 and SEG_W = 7.
  - Digit index typedef (3-bit).
  - FSM state enum.
  - Digit index constants: DIG_HOURS_MSB = 0 .. DIG_SECONDS_LSB = 5.
- Sub-module display_scan_timer: the slot_cnt/dig counters, slot-end and frame_start generation, and the IDLE clear.
- The top level holds the shadow registers, the FSM and the PWM compare.

Test Plan:
All tests use DIGIT_CYCLES = 16, BLANK_CYCLES = 2 (so A = 14).
1. Full brightness scan. Reset, then i_en = 1, i_brightness = 7, hours_msb = 7'h06, seconds_lsb = 7'h3F.
   -> o_frame_start is high for 1 cycle; select 0 for 2 cycles; 6'b100000 with segments 7'h06 for 14 cycles; ... 6'b000001 with 7'h3F. Next frame_start follows exactly 96 cycles later.
2. PWM duty. brightness = 3 -> each digit ON 7 cycles, OFF 7 cycles. brightness = 0 -> ON 1 cycle, OFF 13 cycles.
3. Tear-free update. Change i_minutes_lsb from 7'h5B to 7'h4F during the hours_lsb slot.
   -> the minutes_lsb slot still shows 7'h5B; 7'h4F appears only after the next frame_start.
4. Enable drop. Drop i_en during the ON phase of dig 3.
   -> next cycle all outputs are 0 and stay 0. Re-assert i_en -> frame_start pulse, and the first ON slot is bit5.
5. Asynchronous reset. Assert i_reset between clock edges during ON.
   -> outputs are 0 before the next edge. Release -> IDLE until i_en is sampled high.
6. Blink (DISPLAY_BLINK_EN, BLINK_FRAMES = 2, mask = 3'b001).
   -> seconds digits are lit in frames 0-1, dark in frames 2-3, lit in frames 4-5. Hours and minutes are unaffected throughout.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned SEG_W      = 7;

    typedef logic [2:0] dig_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ON,
        ST_OFF
    } scan_state_t;

    localparam dig_idx_t DIG_HOURS_MSB   = 3'd0;
    localparam dig_idx_t DIG_HOURS_LSB   = 3'd1;
    localparam dig_idx_t DIG_MINUTES_MSB = 3'd2;
    localparam dig_idx_t DIG_MINUTES_LSB = 3'd3;
    localparam dig_idx_t DIG_SECONDS_MSB = 3'd4;
    localparam dig_idx_t DIG_SECONDS_LSB = 3'd5;

    // Lit length of a slot: eighths of the non-blanked part, never zero so
    // the dimmest setting still shows something.
    function automatic int unsigned calc_on_len(input logic [2:0]  brightness,
                                                input int unsigned active_len);
        int unsigned len;
        len = (({29'd0, brightness} + 32'd1) * active_len) >> 3;
        if (len == 0) begin
            len = 1;
        end
        return len;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Digit-pattern inputs and pin-side outputs of the scan controller.
// DISPLAY_BLINK_EN adds the per-pair blink mask.
interface display_scan_ctrl_if;
    import display_pkg::*;

    logic                  i_en;
    logic [SEG_W-1:0]      i_hours_msb;
    logic [SEG_W-1:0]      i_hours_lsb;
    logic [SEG_W-1:0]      i_minutes_msb;
    logic [SEG_W-1:0]      i_minutes_lsb;
    logic [SEG_W-1:0]      i_seconds_msb;
    logic [SEG_W-1:0]      i_seconds_lsb;
    logic [2:0]            i_brightness;
`ifdef DISPLAY_BLINK_EN
    logic [2:0]            i_blink_mask;
`endif
    logic [SEG_W-1:0]      o_segments;
    logic [NUM_DIGITS-1:0] o_digit_sel;
    logic                  o_frame_start;

    modport master (
        output i_en, i_hours_msb, i_hours_lsb, i_minutes_msb, i_minutes_lsb,
               i_seconds_msb, i_seconds_lsb, i_brightness,
`ifdef DISPLAY_BLINK_EN
               i_blink_mask,
`endif
        input  o_segments, o_digit_sel, o_frame_start
    );

    modport slave (
        input  i_en, i_hours_msb, i_hours_lsb, i_minutes_msb, i_minutes_lsb,
               i_seconds_msb, i_seconds_lsb, i_brightness,
`ifdef DISPLAY_BLINK_EN
               i_blink_mask,
`endif
        output o_segments, o_digit_sel, o_frame_start
    );

endinterface

// File: rtl/display_scan_timer.sv
// Slot and digit counters for the scan: slot_cnt walks one digit slot,
// dig walks hours_msb..seconds_lsb. Flags the last cycle of a slot, the edge
// on which a new frame begins, and drives the registered frame_start pulse.
module display_scan_timer
    import display_pkg::*;
#(
    parameter  int unsigned DIGIT_CYCLES = 1000,
    localparam int unsigned CNT_W        = $clog2(DIGIT_CYCLES)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_active,
    output logic [CNT_W-1:0] o_slot_cnt,
    output dig_idx_t         o_dig,
    output logic             o_slot_end,
    output logic             o_frame_load,
    output logic             o_frame_start
);

    assign o_slot_end   = (o_slot_cnt == CNT_W'(DIGIT_CYCLES - 1));
    // A frame begins either on the enable edge out of idle or after the last slot.
    assign o_frame_load = i_en && (!i_active || (o_slot_end && (o_dig == DIG_SECONDS_LSB)));

    // Advance slot/digit counters; idle or disabled holds them cleared.
    // NOTE: state registers use <= so every flop samples pre-edge values; a
    // blocking = here would make results depend on block evaluation order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_slot_cnt    <= '0;
            o_dig         <= DIG_HOURS_MSB;
            o_frame_start <= 1'b0;
        end else if (!i_en) begin
            o_slot_cnt    <= '0;
            o_dig         <= DIG_HOURS_MSB;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= o_frame_load;
            if (!i_active || o_slot_end) begin
                o_slot_cnt <= '0;
            end else begin
                o_slot_cnt <= o_slot_cnt + CNT_W'(1);
            end
            if (o_frame_load) begin
                o_dig <= DIG_HOURS_MSB;
            end else if (o_slot_end) begin
                o_dig <= o_dig + 3'd1;
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed six-digit 7-segment scan controller with inter-digit blanking,
// 8-level PWM brightness and frame-synchronous input capture.
// Optional feature macro: DISPLAY_BLINK_EN (per-pair blink, i_blink_mask).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 8
`ifdef DISPLAY_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 30
`endif
) (
    input logic                i_clk,
    input logic                i_reset,
    display_scan_ctrl_if.slave bus
);

    localparam int unsigned CNT_W      = $clog2(DIGIT_CYCLES);
    localparam int unsigned ACTIVE_LEN = DIGIT_CYCLES - BLANK_CYCLES;

    scan_state_t           state;
    logic [CNT_W-1:0]      slot_cnt;
    dig_idx_t              dig;
    logic                  slot_end;
    logic                  frame_load;
    logic [SEG_W-1:0]      shadow [NUM_DIGITS];
    logic [2:0]            bright_shadow;
    int unsigned           on_last;
    logic                  lit;
    logic [NUM_DIGITS-1:0] on_sel;
    logic [SEG_W-1:0]      on_seg;

    display_scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES)
    ) u_timer (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_en          (bus.i_en),
        .i_active      (state != ST_IDLE),
        .o_slot_cnt    (slot_cnt),
        .o_dig         (dig),
        .o_slot_end    (slot_end),
        .o_frame_load  (frame_load),
        .o_frame_start (bus.o_frame_start)
    );

    // Slot count of the final lit cycle for the captured brightness.
    assign on_last = BLANK_CYCLES + calc_on_len(bright_shadow, ACTIVE_LEN) - 1;

    // Capture the digit patterns and brightness only at frame boundaries.
    // NOTE: the shadow bank is reset like ordinary flops because the outputs
    // must be defined zero after reset; it is only six words.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
            end
            bright_shadow <= '0;
        end else if (frame_load) begin
            shadow[DIG_HOURS_MSB]   <= bus.i_hours_msb;
            shadow[DIG_HOURS_LSB]   <= bus.i_hours_lsb;
            shadow[DIG_MINUTES_MSB] <= bus.i_minutes_msb;
            shadow[DIG_MINUTES_LSB] <= bus.i_minutes_lsb;
            shadow[DIG_SECONDS_MSB] <= bus.i_seconds_msb;
            shadow[DIG_SECONDS_LSB] <= bus.i_seconds_lsb;
            bright_shadow           <= bus.i_brightness;
        end
    end

`ifdef DISPLAY_BLINK_EN
    logic [2:0]                          mask_shadow;
    logic                                blink_phase;
    logic [$clog2(BLINK_FRAMES+1)-1:0]   frame_cnt;
    logic [1:0]                          pair;

    // Capture the blink mask alongside the digit patterns.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mask_shadow <= '0;
        end else if (frame_load) begin
            mask_shadow <= bus.i_blink_mask;
        end
    end

    // Toggle the blink phase every BLINK_FRAMES frames; restarts dark-free.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (state == ST_IDLE || !bus.i_en) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_load) begin
            if (32'(frame_cnt) == BLINK_FRAMES - 1) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Mask bit 2 covers the hours pair, bit 0 the seconds pair.
    assign pair = 2'd2 - 2'(dig >> 1);
    assign lit  = !(blink_phase && mask_shadow[pair]);
`else
    assign lit = 1'b1;
`endif

    // Select and pattern to present when the current slot turns on.
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        on_sel = '0;
        on_seg = '0;
        if (lit) begin
            on_sel = 6'b10_0000 >> dig;
            on_seg = shadow[dig];
        end
    end

    // Slot FSM: blank, lit for on_len cycles, dark for the remainder.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            bus.o_digit_sel <= '0;
            bus.o_segments  <= '0;
        end else if (state != ST_IDLE && !bus.i_en) begin
            state           <= ST_IDLE;
            bus.o_digit_sel <= '0;
            bus.o_segments  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_en) begin
                        state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (32'(slot_cnt) == BLANK_CYCLES - 1) begin
                        state           <= ST_ON;
                        bus.o_digit_sel <= on_sel;
                        bus.o_segments  <= on_seg;
                    end
                end
                ST_ON: begin
                    // Slot end wins so a full-length lit phase skips OFF.
                    if (slot_end) begin
                        state           <= ST_BLANK;
                        bus.o_digit_sel <= '0;
                        bus.o_segments  <= '0;
                    end else if (32'(slot_cnt) == on_last) begin
                        state           <= ST_OFF;
                        bus.o_digit_sel <= '0;
                        bus.o_segments  <= '0;
                    end
                end
                ST_OFF: begin
                    if (slot_end) begin
                        state <= ST_BLANK;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with DIGIT_CYCLES=16, BLANK_CYCLES=2.
// Expected outputs come from a frame-position model: the cycle count since
// enable gives digit and slot offset directly.
module tb_display_scan_ctrl;
    import display_pkg::*;

    localparam int DC    = 16;
    localparam int BC    = 2;
    localparam int FRAME = 6 * DC;
`ifdef DISPLAY_BLINK_EN
    localparam int BF    = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    display_scan_ctrl_if bus();

    display_scan_ctrl #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
`ifdef DISPLAY_BLINK_EN
        ,
        .BLINK_FRAMES (BF)
`endif
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Reference model state
    bit         m_active = 1'b0;
    int         m_k      = 0;
    logic [6:0] m_snap [6];
    logic [2:0] m_bright;
    logic [2:0] m_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_all();
        return {18'd0, bus.o_frame_start, bus.o_digit_sel, bus.o_segments};
    endfunction

    task automatic load_snap();
        m_snap[0] = bus.i_hours_msb;
        m_snap[1] = bus.i_hours_lsb;
        m_snap[2] = bus.i_minutes_msb;
        m_snap[3] = bus.i_minutes_lsb;
        m_snap[4] = bus.i_seconds_msb;
        m_snap[5] = bus.i_seconds_lsb;
        m_bright  = bus.i_brightness;
`ifdef DISPLAY_BLINK_EN
        m_mask    = bus.i_blink_mask;
`else
        m_mask    = 3'b000;
`endif
    endtask

    function automatic logic [31:0] model_out();
        logic [31:0] r;
        int d, s, on;
        r = '0;
        if (m_active) begin
            d  = (m_k % FRAME) / DC;
            s  = m_k % DC;
            on = ((int'(m_bright) + 1) * (DC - BC)) / 8;
            if (on < 1) on = 1;
            if (s >= BC && s < BC + on) begin
                r[12:7] = 6'b100000 >> d;
                r[6:0]  = m_snap[d];
            end
`ifdef DISPLAY_BLINK_EN
            if ((((m_k / FRAME) / BF) % 2) == 1 && m_mask[2 - d / 2]) r[12:0] = '0;
`endif
            r[13] = ((m_k % FRAME) == 0);
        end
        return r;
    endfunction

    // One clock: advance the model from the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (bus.i_en) begin
                m_active = 1'b1;
                m_k      = 0;
                load_snap();
            end
        end else if (!bus.i_en) begin
            m_active = 1'b0;
        end else begin
            m_k++;
            if ((m_k % FRAME) == 0) load_snap();
        end
        #1;
        check("scan", obs_all(), model_out());
    endtask

    task automatic run_until(input int p);
        int n;
        n = 0;
        while (!(m_active && (m_k % FRAME) == p) && n < 4 * FRAME) begin
            tick();
            n++;
        end
        check("run_until_bound", 32'(n < 4 * FRAME), 32'd1);
    endtask

    // Counts lit cycles over the 14 non-blanked cycles of the next slot.
    task automatic count_lit(output int n);
        n = 0;
        for (int i = 0; i < DC - BC; i++) begin
            tick();
            if (bus.o_digit_sel != '0) n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst               = 1'b1;
        bus.i_en          = 1'b0;
        bus.i_hours_msb   = 7'h06;
        bus.i_hours_lsb   = 7'h5B;
        bus.i_minutes_msb = 7'h4F;
        bus.i_minutes_lsb = 7'h5B;
        bus.i_seconds_msb = 7'h66;
        bus.i_seconds_lsb = 7'h3F;
        bus.i_brightness  = 3'd7;
`ifdef DISPLAY_BLINK_EN
        bus.i_blink_mask  = 3'b000;
`endif
        #2;
        check("reset_outputs", obs_all(), 32'd0);
        tick();
        tick();
        #2 rst = 1'b0;
        repeat (3) tick();

        // Full brightness scan
        bus.i_en = 1'b1;
        tick();
        check("t1_frame_start", obs_all(), {18'd0, 1'b1, 6'b000000, 7'h00});
        tick();
        count_lit(n);
        check("t1_on_cycles", 32'(n), 32'd14);
        run_until(82);
        check("t1_seconds_lsb", obs_all(), {18'd0, 1'b0, 6'b000001, 7'h3F});
        run_until(0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.o_frame_start && n < 200);
        check("frame_period", 32'(n), 32'd96);

        // PWM duty
        bus.i_brightness = 3'd3;
        tick();
        run_until(0);
        tick();
        count_lit(n);
        check("duty_b3", 32'(n), 32'd7);
        bus.i_brightness = 3'd0;
        tick();
        run_until(0);
        tick();
        count_lit(n);
        check("duty_b0", 32'(n), 32'd1);

        // Tear-free update
        bus.i_brightness = 3'd7;
        tick();
        run_until(0);
        run_until(20);
        bus.i_minutes_lsb = 7'h4F;
        run_until(50);
        check("tear_old", obs_all(), {18'd0, 1'b0, 6'b000100, 7'h5B});
        tick();
        run_until(50);
        check("tear_new", obs_all(), {18'd0, 1'b0, 6'b000100, 7'h4F});

        // Enable drop during dig 3 ON
        tick();
        run_until(52);
        bus.i_en = 1'b0;
        tick();
        check("drop_out", obs_all(), 32'd0);
        repeat (4) tick();
        bus.i_en = 1'b1;
        tick();
        check("reen_frame_start", obs_all(), {18'd0, 1'b1, 6'b000000, 7'h00});
        run_until(2);
        check("reen_first_sel", obs_all(), {18'd0, 1'b0, 6'b100000, 7'h06});

        // Asynchronous reset mid-ON
        run_until(20);
        #3 rst = 1'b1;
        #1;
        check("async_reset", obs_all(), 32'd0);
        bus.i_en = 1'b0;
        tick();
        #2 rst = 1'b0;
        repeat (3) tick();
        check("idle_after_reset", obs_all(), 32'd0);
        bus.i_en = 1'b1;
        tick();
        check("restart_frame_start", obs_all(), {18'd0, 1'b1, 6'b000000, 7'h00});

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 5))
                    0: bus.i_hours_msb   = 7'($urandom);
                    1: bus.i_hours_lsb   = 7'($urandom);
                    2: bus.i_minutes_msb = 7'($urandom);
                    3: bus.i_minutes_lsb = 7'($urandom);
                    4: bus.i_seconds_msb = 7'($urandom);
                    default: bus.i_seconds_lsb = 7'($urandom);
                endcase
            end
            if ($urandom_range(0, 39) == 0) bus.i_brightness = 3'($urandom);
            if ($urandom_range(0, 299) == 0) bus.i_en = 1'b0;
            else if (!bus.i_en && $urandom_range(0, 3) == 0) bus.i_en = 1'b1;
            tick();
        end

`ifdef DISPLAY_BLINK_EN
        // Blink on the seconds pair
        bus.i_en = 1'b0;
        tick();
        bus.i_blink_mask = 3'b001;
        bus.i_brightness = 3'd7;
        bus.i_en         = 1'b1;
        repeat (6 * FRAME) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
